regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Arbitrates two write requesters onto the write port of a register file and
// runs a clear walk that zeroes every register, one per cycle, after reset or
// on request.
//
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-high reset
//   reqN_valid/addr/data  write request from requester N (N = 0, 1)
//   reqN_ready            requester N is accepted this cycle (combinational)
//   clear_start           pulse in RUN: start a clear walk over all registers
//   wr_en                 registered one-hot write enable, one bit per register
//   wr_data               registered write data shared by all registers
//   busy                  clear walk in progress (requests are not accepted)
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  clear_start,
  output logic [NUM_REGS-1:0]   wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  logic [0:0]            state_q,      state_d;
  logic [ADDR_WIDTH-1:0] cnt_q,        cnt_d;
  // 1 = requester 1 was granted most recently, so requester 0 wins a tie.
  logic                  last_grant_q, last_grant_d;
  logic [NUM_REGS-1:0]   wr_en_q,      wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q,    wr_data_d;

  logic                  gnt0;
  logic                  gnt1;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // One-hot decode of a register index; indices at or beyond NUM_REGS decode
  // to all zeros.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_WIDTH-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      v[i] = (idx == ADDR_WIDTH'(i));
    end
    return v;
  endfunction

  // Next-state, grant and write-port logic for the CLEAR/RUN controller.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    wr_en_d      = '0;
    wr_data_d    = wr_data_q;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    sel_addr     = req0_addr;
    sel_data     = req0_data;
    case (state_q)
      ST_CLEAR: begin
        wr_en_d   = onehot(cnt_q);
        wr_data_d = '0;
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (clear_start) begin
          // Clear has priority over any pending request this cycle.
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          gnt0 = req0_valid & (~req1_valid | last_grant_q);
          gnt1 = req1_valid & (~req0_valid | ~last_grant_q);
          if (gnt1) begin
            sel_addr = req1_addr;
            sel_data = req1_data;
          end else begin
            sel_addr = req0_addr;
            sel_data = req0_data;
          end
          if (gnt0 | gnt1) begin
            last_grant_d = gnt1;
            wr_data_d    = sel_data;
            // r0 is hardwired zero: the write is accepted but enables nothing.
            if (sel_addr != '0) begin
              wr_en_d = onehot(sel_addr);
            end else begin
              wr_en_d = '0;
            end
          end else begin
            wr_en_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // State, clear counter, arbitration history and registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      wr_en_q      <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
    end
  end

  // Reset holds state_q at CLEAR, which already forces busy high and both
  // readies low while reset is asserted.
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign busy       = (state_q == ST_CLEAR);
  assign wr_en      = wr_en_q;
  assign wr_data    = wr_data_q;

endmodule
